// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one column per sw_clk edge, frame-level debounce,
// one key_valid pulse per accepted press, key_held until accepted release.
module keypad_scanner #(
    parameter int COLS            = 4,
    parameter int ROWS            = 4,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic                            clock_50m,
    input  logic                            rst,
    input  logic                            sw_clk,
    input  logic [ROWS-1:0]                 key_row,
    output logic [COLS-1:0]                 key_col,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_valid,
    output logic                            key_held
);

    localparam int N      = ROWS * COLS;
    localparam int CODE_W = $clog2(N);
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CNT_W-1:0]  DF       = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [COLS-1:0]   COL_RST  = {{(COLS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        PRESSED = 2'd2
    } state_t;

    logic            sw_s1, sw_s2, sw_prev;
    logic [ROWS-1:0] row_s1, row_s2;
    logic            scan_tick;
    logic            frame_end;
    logic [COL_W-1:0] col_idx, col_nxt;
    logic [N-1:0]    acc, acc_mix;
    logic [N-1:0]    frame_vec;
    logic            frame_done;

    state_t              state, state_n;
    logic [CODE_W-1:0]   cand, cand_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [CNT_W-1:0]    rcnt, rcnt_n;
    logic [CODE_W-1:0]   code_n;
    logic                valid_n, held_n;

    logic [1:0]          hit_cnt;
    logic [CODE_W-1:0]   hit_k;
    logic                is_none, is_single;

    assign scan_tick = sw_s2 & ~sw_prev;
    assign frame_end = scan_tick && (col_idx == COL_LAST);
    assign col_nxt   = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;

    // Closed keys are stored as 1 at bit row*COLS+col.
    always_comb begin
        acc_mix = acc;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_s2[r]) acc_mix[r*COLS + int'(col_idx)] = 1'b1;
        end
    end

    always_ff @(posedge clock_50m) begin
        if (!rst) begin
            sw_s1      <= 1'b0;
            sw_s2      <= 1'b0;
            sw_prev    <= 1'b0;
            row_s1     <= '0;
            row_s2     <= '0;
            col_idx    <= '0;
            key_col    <= COL_RST;
            acc        <= '0;
            frame_vec  <= '0;
            frame_done <= 1'b0;
        end else begin
            sw_s1      <= sw_clk;
            sw_s2      <= sw_s1;
            sw_prev    <= sw_s2;
            row_s1     <= key_row;
            row_s2     <= row_s1;
            frame_done <= frame_end;
            if (scan_tick) begin
                col_idx <= col_nxt;
                key_col <= ~(COLS'(1) << col_nxt);
                if (frame_end) begin
                    frame_vec <= acc_mix;
                    acc       <= '0;
                end else begin
                    acc <= acc_mix;
                end
            end
        end
    end

    // Saturating hit count; hit_k is meaningful only for a single hit.
    always_comb begin
        hit_cnt = 2'd0;
        hit_k   = '0;
        for (int i = 0; i < N; i++) begin
            if (frame_vec[i]) begin
                if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
                hit_k = CODE_W'(i);
            end
        end
    end

    assign is_none   = (hit_cnt == 2'd0);
    assign is_single = (hit_cnt == 2'd1);

    always_ff @(posedge clock_50m) begin
        if (!rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            rcnt      <= rcnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        rcnt_n  = rcnt;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
        if (frame_done) begin
            unique case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_n = hit_k;
                        cnt_n  = CNT_ONE;
                        if (CNT_ONE >= DF) begin
                            code_n  = hit_k;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            rcnt_n  = '0;
                            state_n = PRESSED;
                        end else begin
                            state_n = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (is_single && hit_k == cand) begin
                        if (cnt + 1'b1 >= DF) begin
                            cnt_n   = DF;
                            code_n  = cand;
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            rcnt_n  = '0;
                            state_n = PRESSED;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else if (is_single) begin
                        cand_n = hit_k;
                        cnt_n  = CNT_ONE;
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        if (rcnt + 1'b1 >= DF) begin
                            rcnt_n  = '0;
                            cnt_n   = '0;
                            held_n  = 1'b0;
                            state_n = IDLE;
                        end else begin
                            rcnt_n = rcnt + 1'b1;
                        end
                    end else begin
                        rcnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
